sram_bus_bridge: RTL and testbench
==================================

Name: sram_bus_bridge

Overview:
- Upstream of the two SRAM converter instances (BaseRAM, ExtRAM).
- Arbitrates between the CPU instruction-fetch port and data port, decodes each address to a bank, and sequences a multi-cycle SRAM access with a fixed wait-state count.
- Returns read data with a one-cycle ready pulse.
- Only one access is in flight at a time.

Parameters:
- WAIT_CYCLES, 1, extra cycles the bank enable is held beyond the first access cycle (0..15).
- BASE_ADDR, 32'h8000_0000, start of the BaseRAM window (4 MB).
- EXT_ADDR, 32'h8040_0000, start of the ExtRAM window (4 MB).

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-high
- inst_req  in  1  fetch request; hold until inst_ready
- inst_addr  in  32  fetch byte address
- inst_rdata  out  32  fetch data, valid while inst_ready=1
- inst_ready  out  1  one-cycle completion pulse
- data_req  in  1  load/store request; hold until data_ready
- data_we  in  4  byte write strobes, 0 means read
- data_addr  in  32  byte address
- data_wdata  in  32  store data
- data_rdata  out  32  load data, valid while data_ready=1
- data_ready  out  1  one-cycle completion pulse
- base_en  out  1  BaseRAM converter enable
- base_we  out  4  BaseRAM byte write strobes
- base_addr  out  32  BaseRAM byte address
- base_wdata  out  32  BaseRAM write data
- base_rdata  in  32  BaseRAM converter registered read data
- ext_en, ext_we, ext_addr, ext_wdata, ext_rdata  same widths/directions as base_*, for ExtRAM

Behaviour:
- Reset (resetn=1, async):
  - state=IDLE, all *_en=0, *_we=0, *_addr=0, *_wdata=0.
  - inst_ready=data_ready=0, inst_rdata=data_rdata=0.
  - last_grant=INST.
- States: IDLE, ACCESS, CAPTURE, RESP.
- IDLE: sample inst_req/data_req.
  - Only one pending: grant it.
  - Both pending: grant the port not equal to last_grant, so data wins the first conflict after reset and grants alternate under contention.
  - On grant: latch port id, addr, we (inst: 4'h0), and wdata into internal regs; update last_grant.
  - Decode the latched address:
    - addr[31:22]==BASE_ADDR[31:22]: bank=BASE.
    - addr[31:22]==EXT_ADDR[31:22]: bank=EXT.
    - Otherwise unmapped.
  - Mapped: go to ACCESS with wait counter=WAIT_CYCLES. Unmapped: go to RESP with rdata reg=0; writes are dropped.
- ACCESS: selected bank's en=1, we/addr/wdata from latched regs; other bank en=0, we=0.
  - Counter decrements each cycle.
  - Exit to CAPTURE in the cycle the counter is 0, so en is high for exactly WAIT_CYCLES+1 cycles.
- CAPTURE: all en=0, we=0.
  - Latch the selected bank's rdata into the rdata reg (the converter registered it at the last ACCESS edge); for writes the latch is harmless.
  - Go to RESP.
- RESP: assert the granted port's ready for exactly one cycle, with its rdata output = rdata reg.
  - The other port's ready stays 0; its rdata output holds its previous value.
  - Go to IDLE.
- Latency from req visible in IDLE to ready:
  - Mapped access: WAIT_CYCLES+3 cycles (default 4).
  - Unmapped access: 1 cycle.
- Requester rules:
  - addr/we/wdata may change after the grant cycle; the bridge uses latched copies.
  - req still high in the IDLE cycle after ready is treated as a new request.
- Request dropped before grant: ignored, no response. Request dropped after grant: the access completes and ready still pulses.
- Bank outputs change only on clock edges (registered); no combinational path from req to bank ports.
- Reset mid-access: immediate return to reset values; no ready pulse; the interrupted write may be partial in SRAM.
- Address bits [1:0] are passed through unchanged; alignment is the requester's responsibility.

Test Plan:
- Data read 0x8000_0010, base_rdata=0xDEAD_BEEF, WAIT_CYCLES=1 -> base_en high 2 cycles with base_addr=0x8000_0010, base_we=0; data_ready pulses 4 cycles after req with data_rdata=0xDEAD_BEEF; ext_en stays 0.
- Byte store data_we=4'b0010, addr 0x8040_0004, wdata 0x0000_AB00 -> ext_en=1, ext_we=4'b0010, ext_wdata=0x0000_AB00 for 2 cycles; base_en=0; data_ready one pulse.
- inst_req and data_req both held high from reset -> grants in order data, inst, data, inst; each ready single-cycle; no overlap of base_en/ext_en.
- Data read 0x1FD0_03F8 (unmapped) -> no bank enable; data_ready the cycle after grant with data_rdata=0.
- Assert resetn during ACCESS of a store -> all bank outputs 0 asynchronously, no ready pulse, state IDLE after release; next fetch completes normally.
- WAIT_CYCLES=0 and WAIT_CYCLES=3 builds -> en width 1 and 4 cycles; ready latency 3 and 6 cycles respectively.

Source files
------------

// File: rtl/sram_bus_bridge.sv
// CPU-to-SRAM bridge: arbitrates the fetch and data ports, decodes the address
// to BaseRAM or ExtRAM and runs one wait-stated access at a time.
module sram_bus_bridge #(
   parameter int unsigned WAIT_CYCLES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter logic [31:0] EXT_ADDR    = 32'h8040_0000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic [31:0] inst_rdata,
   output logic        inst_ready,
   input  logic        data_req,
   input  logic [3:0]  data_we,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        data_ready,
   output logic        base_en,
   output logic [3:0]  base_we,
   output logic [31:0] base_addr,
   output logic [31:0] base_wdata,
   input  logic [31:0] base_rdata,
   output logic        ext_en,
   output logic [3:0]  ext_we,
   output logic [31:0] ext_addr,
   output logic [31:0] ext_wdata,
   input  logic [31:0] ext_rdata
);

   localparam int unsigned CNT_W = 4;
   localparam logic PORT_INST = 1'b0;
   localparam logic PORT_DATA = 1'b1;
   localparam logic BANK_BASE = 1'b0;
   localparam logic BANK_EXT  = 1'b1;

   typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

   state_t             state;
   logic               last_grant;
   logic               port_q;
   logic               bank_q;
   logic [CNT_W-1:0]   cnt_q;

   logic               grant_c;
   logic               grant_data_c;
   logic [31:0]        sel_addr_c;
   logic [3:0]         sel_we_c;
   logic [31:0]        sel_wdata_c;
   logic               hit_base_c;
   logic               hit_ext_c;
   logic [31:0]        bank_rdata_c;

   // Round-robin choice and bank decode of the request presented in IDLE
   always_comb begin
      grant_c      = inst_req | data_req;
      grant_data_c = data_req & (~inst_req | (last_grant == PORT_INST));
      sel_addr_c   = grant_data_c ? data_addr  : inst_addr;
      sel_we_c     = grant_data_c ? data_we    : 4'h0;
      sel_wdata_c  = grant_data_c ? data_wdata : 32'h0;
      hit_base_c   = (sel_addr_c[31:22] == BASE_ADDR[31:22]);
      hit_ext_c    = (sel_addr_c[31:22] == EXT_ADDR[31:22]);
      bank_rdata_c = (bank_q == BANK_EXT) ? ext_rdata : base_rdata;
   end

   // Access sequencer; bank and response outputs are loaded directly as registers
   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         state      <= IDLE;
         last_grant <= PORT_INST;
         port_q     <= PORT_INST;
         bank_q     <= BANK_BASE;
         cnt_q      <= '0;
         base_en    <= 1'b0;
         base_we    <= 4'h0;
         base_addr  <= 32'h0;
         base_wdata <= 32'h0;
         ext_en     <= 1'b0;
         ext_we     <= 4'h0;
         ext_addr   <= 32'h0;
         ext_wdata  <= 32'h0;
         inst_ready <= 1'b0;
         inst_rdata <= 32'h0;
         data_ready <= 1'b0;
         data_rdata <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_c) begin
                  port_q     <= grant_data_c;
                  last_grant <= grant_data_c;
                  cnt_q      <= CNT_W'(WAIT_CYCLES);
                  if (hit_base_c) begin
                     bank_q     <= BANK_BASE;
                     base_en    <= 1'b1;
                     base_we    <= sel_we_c;
                     base_addr  <= sel_addr_c;
                     base_wdata <= sel_wdata_c;
                     state      <= ACCESS;
                  end else if (hit_ext_c) begin
                     bank_q    <= BANK_EXT;
                     ext_en    <= 1'b1;
                     ext_we    <= sel_we_c;
                     ext_addr  <= sel_addr_c;
                     ext_wdata <= sel_wdata_c;
                     state     <= ACCESS;
                  end else begin
                     // Unmapped: answer immediately with zero, stores are dropped
                     if (grant_data_c == PORT_DATA) begin
                        data_ready <= 1'b1;
                        data_rdata <= 32'h0;
                     end else begin
                        inst_ready <= 1'b1;
                        inst_rdata <= 32'h0;
                     end
                     state <= RESP;
                  end
               end
            end
            ACCESS: begin
               if (cnt_q == '0) begin
                  base_en <= 1'b0;
                  base_we <= 4'h0;
                  ext_en  <= 1'b0;
                  ext_we  <= 4'h0;
                  state   <= CAPTURE;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            CAPTURE: begin
               // Converter registered its read data at the last ACCESS edge
               if (port_q == PORT_DATA) begin
                  data_ready <= 1'b1;
                  data_rdata <= bank_rdata_c;
               end else begin
                  inst_ready <= 1'b1;
                  inst_rdata <= bank_rdata_c;
               end
               state <= RESP;
            end
            RESP: begin
               inst_ready <= 1'b0;
               data_ready <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_bus_bridge.sv
// Bench for sram_bus_bridge: three builds (WAIT_CYCLES 0, 1, 3) driven by
// directed and random transactions, checked against a transaction-level model.
module tb_sram_bus_bridge;

   localparam int unsigned NDUT = 3;
   localparam int unsigned WAIT_TAB [NDUT] = '{0, 1, 3};

   logic        clk = 1'b0;
   logic        resetn;

   logic        inst_req   [NDUT];
   logic [31:0] inst_addr  [NDUT];
   logic [31:0] inst_rdata [NDUT];
   logic        inst_ready [NDUT];
   logic        data_req   [NDUT];
   logic [3:0]  data_we    [NDUT];
   logic [31:0] data_addr  [NDUT];
   logic [31:0] data_wdata [NDUT];
   logic [31:0] data_rdata [NDUT];
   logic        data_ready [NDUT];
   logic        base_en    [NDUT];
   logic [3:0]  base_we    [NDUT];
   logic [31:0] base_addr  [NDUT];
   logic [31:0] base_wdata [NDUT];
   logic [31:0] base_rdata [NDUT];
   logic        ext_en     [NDUT];
   logic [3:0]  ext_we     [NDUT];
   logic [31:0] ext_addr   [NDUT];
   logic [31:0] ext_wdata  [NDUT];
   logic [31:0] ext_rdata  [NDUT];

   int checks = 0;
   int errors = 0;
   int cur_dut = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      sram_bus_bridge #(.WAIT_CYCLES(WAIT_TAB[g])) u_dut (
         .clk        (clk),
         .resetn     (resetn),
         .inst_req   (inst_req[g]),
         .inst_addr  (inst_addr[g]),
         .inst_rdata (inst_rdata[g]),
         .inst_ready (inst_ready[g]),
         .data_req   (data_req[g]),
         .data_we    (data_we[g]),
         .data_addr  (data_addr[g]),
         .data_wdata (data_wdata[g]),
         .data_rdata (data_rdata[g]),
         .data_ready (data_ready[g]),
         .base_en    (base_en[g]),
         .base_we    (base_we[g]),
         .base_addr  (base_addr[g]),
         .base_wdata (base_wdata[g]),
         .base_rdata (base_rdata[g]),
         .ext_en     (ext_en[g]),
         .ext_we     (ext_we[g]),
         .ext_addr   (ext_addr[g]),
         .ext_wdata  (ext_wdata[g]),
         .ext_rdata  (ext_rdata[g])
      );
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL dut%0d %s: observed 0x%08h expected 0x%08h", cur_dut, tag, obs, exp);
      end
   endtask

   // Model: 0 = BaseRAM window, 1 = ExtRAM window, 2 = unmapped
   function automatic int bank_of(input logic [31:0] a);
      if (a >= 32'h8000_0000 && a < 32'h8040_0000) return 0;
      if (a >= 32'h8040_0000 && a < 32'h8080_0000) return 1;
      return 2;
   endfunction

   task automatic apply_reset();
      @(negedge clk);
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      resetn = 1'b0;
   endtask

   task automatic chk_reset_state(input int d);
      cur_dut = d;
      chk("rst_ctrl", 32'({base_en[d], base_we[d], ext_en[d], ext_we[d], inst_ready[d], data_ready[d]}), 32'h0);
      chk("rst_base_addr", base_addr[d], 32'h0);
      chk("rst_base_wdata", base_wdata[d], 32'h0);
      chk("rst_ext_addr", ext_addr[d], 32'h0);
      chk("rst_ext_wdata", ext_wdata[d], 32'h0);
      chk("rst_inst_rdata", inst_rdata[d], 32'h0);
      chk("rst_data_rdata", data_rdata[d], 32'h0);
   endtask

   // One transaction from an idle bridge; starts and ends on a falling edge
   task automatic do_xfer(input int d, input bit is_data, input logic [31:0] addr,
                          input logic [3:0] we, input logic [31:0] wdata,
                          input logic [31:0] rv_b, input logic [31:0] rv_e);
      int          bank;
      int          w;
      int          exp_lat;
      int          exp_en;
      int          lat = 0;
      int          en_cnt = 0;
      int          stray = 0;
      int          other_rdy = 0;
      bit          got = 1'b0;
      logic [31:0] rd = 32'h0;
      logic [31:0] other_before;
      logic [31:0] exp_rd;
      logic        t_en;
      logic [3:0]  t_we;
      logic [31:0] t_addr;
      logic [31:0] t_wdata;
      cur_dut = d;
      bank    = bank_of(addr);
      w       = int'(WAIT_TAB[d]);
      exp_lat = (bank == 2) ? 1 : w + 3;
      exp_en  = (bank == 2) ? 0 : w + 1;
      exp_rd  = (bank == 0) ? rv_b : (bank == 1) ? rv_e : 32'h0;
      base_rdata[d] = rv_b;
      ext_rdata[d]  = rv_e;
      other_before  = is_data ? inst_rdata[d] : data_rdata[d];
      if (is_data) begin
         data_req[d] = 1'b1; data_we[d] = we; data_addr[d] = addr; data_wdata[d] = wdata;
      end else begin
         inst_req[d] = 1'b1; inst_addr[d] = addr;
      end
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         t_en    = (bank == 1) ? ext_en[d]    : base_en[d];
         t_we    = (bank == 1) ? ext_we[d]    : base_we[d];
         t_addr  = (bank == 1) ? ext_addr[d]  : base_addr[d];
         t_wdata = (bank == 1) ? ext_wdata[d] : base_wdata[d];
         if (bank == 2) begin
            if (base_en[d] || ext_en[d]) stray++;
         end else if ((bank == 0) ? ext_en[d] : base_en[d]) begin
            stray++;
         end
         if (bank != 2 && t_en) begin
            en_cnt++;
            chk("bank_addr", t_addr, addr);
            chk("bank_we", 32'(t_we), 32'(is_data ? we : 4'h0));
            if (is_data && we != 4'h0) chk("bank_wdata", t_wdata, wdata);
         end
         if (is_data ? inst_ready[d] : data_ready[d]) other_rdy++;
         if (c == 1) begin
            // Requester may move its fields once granted
            if (is_data) begin
               data_addr[d] = $urandom; data_wdata[d] = $urandom; data_we[d] = 4'($urandom);
            end else begin
               inst_addr[d] = $urandom;
            end
         end
         if (is_data ? data_ready[d] : inst_ready[d]) begin
            got = 1'b1;
            lat = c;
            rd  = is_data ? data_rdata[d] : inst_rdata[d];
            break;
         end
      end
      if (is_data) data_req[d] = 1'b0; else inst_req[d] = 1'b0;
      chk("ready_seen", 32'(got), 32'h1);
      chk("latency", 32'(lat), 32'(exp_lat));
      chk("en_cycles", 32'(en_cnt), 32'(exp_en));
      chk("stray_en", 32'(stray), 32'h0);
      chk("other_ready", 32'(other_rdy), 32'h0);
      if (!is_data || we == 4'h0) chk("rdata", rd, exp_rd);
      chk("other_rdata_held", is_data ? inst_rdata[d] : data_rdata[d], other_before);
      @(negedge clk);
      chk("ready_width", 32'(is_data ? data_ready[d] : inst_ready[d]), 32'h0);
      chk("en_idle", 32'({base_en[d], ext_en[d]}), 32'h0);
   endtask

   // Both ports held high straight out of reset
   task automatic contend(input int d);
      int   w;
      int   n = 0;
      int   dual = 0;
      int   overlap = 0;
      int   wide = 0;
      int   port_seq [4];
      int   cyc_seq  [4];
      logic prev_i = 1'b0;
      logic prev_d = 1'b0;
      apply_reset();
      cur_dut = d;
      w = int'(WAIT_TAB[d]);
      base_rdata[d] = 32'h1111_0000;
      ext_rdata[d]  = 32'h2222_0000;
      inst_addr[d]  = 32'h8000_0100;
      data_addr[d]  = 32'h8040_0200;
      data_we[d]    = 4'h0;
      inst_req[d]   = 1'b1;
      data_req[d]   = 1'b1;
      for (int c = 1; c <= 80 && n < 4; c++) begin
         @(negedge clk);
         if (inst_ready[d] && data_ready[d]) dual++;
         if (base_en[d] && ext_en[d]) overlap++;
         if ((inst_ready[d] && prev_i) || (data_ready[d] && prev_d)) wide++;
         prev_i = inst_ready[d];
         prev_d = data_ready[d];
         if (inst_ready[d] || data_ready[d]) begin
            port_seq[n] = data_ready[d] ? 1 : 0;
            cyc_seq[n]  = c;
            n++;
         end
      end
      inst_req[d] = 1'b0;
      data_req[d] = 1'b0;
      chk("arb_count", 32'(n), 32'h4);
      for (int k = 0; k < 4 && k < n; k++) begin
         chk($sformatf("arb_port%0d", k), 32'(port_seq[k]), 32'((k % 2 == 0) ? 1 : 0));
         chk($sformatf("arb_cycle%0d", k), 32'(cyc_seq[k]), 32'((k + 1) * (w + 3) + k));
      end
      chk("arb_dual_ready", 32'(dual), 32'h0);
      chk("arb_bank_overlap", 32'(overlap), 32'h0);
      chk("arb_wide_ready", 32'(wide), 32'h0);
      @(negedge clk);
      chk("arb_quiet", 32'({inst_ready[d], data_ready[d]}), 32'h0);
   endtask

   // Reset asserted while a store holds the bank enabled
   task automatic reset_mid_store(input int d);
      int rdy = 0;
      cur_dut = d;
      data_req[d] = 1'b1; data_we[d] = 4'hF;
      data_addr[d] = 32'h8000_0040; data_wdata[d] = 32'hCAFE_F00D;
      @(negedge clk);
      chk("rm_en_before", 32'(base_en[d]), 32'h1);
      resetn = 1'b1;
      data_req[d] = 1'b0;
      #1;
      chk("rm_async_ctrl", 32'({base_en[d], base_we[d], ext_en[d], ext_we[d]}), 32'h0);
      chk("rm_async_addr", base_addr[d], 32'h0);
      chk("rm_async_wdata", base_wdata[d], 32'h0);
      repeat (2) begin
         @(negedge clk);
         if (data_ready[d] || inst_ready[d]) rdy++;
      end
      resetn = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (data_ready[d] || inst_ready[d] || base_en[d] || ext_en[d]) rdy++;
      end
      chk("rm_no_ready", 32'(rdy), 32'h0);
      do_xfer(d, 1'b0, 32'h8000_0800, 4'h0, 32'h0, 32'h600D_F00D, 32'hBAD0_BAD0);
   endtask

   initial begin
      resetn = 1'b1;
      for (int d = 0; d < NDUT; d++) begin
         inst_req[d] = 1'b0; inst_addr[d] = 32'h0;
         data_req[d] = 1'b0; data_we[d] = 4'h0; data_addr[d] = 32'h0; data_wdata[d] = 32'h0;
         base_rdata[d] = 32'h0; ext_rdata[d] = 32'h0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < NDUT; d++) chk_reset_state(d);
      resetn = 1'b0;

      for (int d = 0; d < NDUT; d++) begin
         do_xfer(d, 1'b1, 32'h8000_0010, 4'h0, 32'h0, 32'hDEAD_BEEF, 32'h0BAD_0BAD);
         do_xfer(d, 1'b1, 32'h8040_0004, 4'b0010, 32'h0000_AB00, 32'h1234_5678, 32'h9ABC_DEF0);
         do_xfer(d, 1'b1, 32'h1FD0_03F8, 4'h0, 32'h0, 32'h5555_5555, 32'hAAAA_AAAA);
         do_xfer(d, 1'b0, 32'h803F_FFFC, 4'h0, 32'h0, 32'h0F0F_0F0F, 32'hF0F0_F0F0);
         do_xfer(d, 1'b0, 32'h8080_0000, 4'h0, 32'h0, 32'h7777_7777, 32'h8888_8888);
         for (int i = 0; i < 30; i++) begin
            logic [31:0] a;
            logic [3:0]  we;
            bit          isd;
            int          sel;
            sel = int'($urandom_range(0, 2));
            if (sel == 0)      a = 32'h8000_0000 + ($urandom & 32'h003F_FFFF);
            else if (sel == 1) a = 32'h8040_0000 + ($urandom & 32'h003F_FFFF);
            else if ($urandom_range(0, 1) == 0) a = $urandom & 32'h7FFF_FFFF;
            else               a = 32'h8080_0000 | $urandom;
            isd = 1'($urandom_range(0, 1));
            we  = (isd && $urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            do_xfer(d, isd, a, we, $urandom, $urandom, $urandom);
         end
         contend(d);
         reset_mid_store(d);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
